// File: rtl/gaussian_job_sched.sv
// Job sequencer for the Gaussian accelerator: streams reads from src_base, buffers the
// non-stallable datapath output in a credit-limited FIFO, writes it to dst_base, then posts status.
module gaussian_job_sched #(
  parameter int ADDR_W     = 42,
  parameter int LEN_W      = 32,
  parameter int FIFO_DEPTH = 64,
  parameter int DATA_W     = 512
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W-1:0] dsm_base,
  input  logic [LEN_W-1:0]  num_lines,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  input  logic              c0_alm_full,
  input  logic              c1_alm_full,
  output logic              rd_req_valid,
  output logic [ADDR_W-1:0] rd_req_addr,
  output logic [15:0]       rd_req_mdata,
  input  logic              dp_valid,
  input  logic [DATA_W-1:0] dp_data,
  output logic              wr_req_valid,
  output logic [ADDR_W-1:0] wr_req_addr,
  output logic [DATA_W-1:0] wr_req_data,
  input  logic              wr_rsp_valid
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_DSM_WR, S_DSM_WAIT} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   src_q, src_d, dst_q, dst_d, dsm_q, dsm_d;
  logic [LEN_W-1:0]    num_q, num_d, rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d, ack_cnt_q, ack_cnt_d;
  logic [CW-1:0]       credits_q, credits_d, wptr_q, wptr_d, rptr_q, rptr_d;
  logic                ovf_q, ovf_d, done_q, done_d;
  logic                rd_v_q, rd_v_d, wr_v_q, wr_v_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [15:0]         rd_md_q, rd_md_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic                active, fifo_empty, fifo_full, rd_go, wr_go, push_ok;

  assign active     = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = ((wptr_q - rptr_q) == DEPTH_C);
  assign rd_go      = (state_q == S_RUN) && !c0_alm_full && (rd_cnt_q < num_q) && (credits_q < DEPTH_C);
  assign wr_go      = active && !fifo_empty && !c1_alm_full;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign push_ok    = active && dp_valid && (!fifo_full || wr_go);

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    dsm_d     = dsm_q;
    num_d     = num_q;
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    ack_cnt_d = ack_cnt_q;
    credits_d = credits_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    rd_v_d    = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_md_d   = rd_md_q;
    wr_v_d    = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    unique case (state_q)
      S_IDLE: if (start) begin
        state_d   = S_RUN;
        src_d     = src_base;
        dst_d     = dst_base;
        dsm_d     = dsm_base;
        num_d     = num_lines;
        rd_cnt_d  = '0;
        wr_cnt_d  = '0;
        ack_cnt_d = '0;
        credits_d = '0;
        wptr_d    = '0;
        rptr_d    = '0;
        ovf_d     = 1'b0;
      end
      S_RUN: begin
        if (num_q == '0)           state_d = S_DSM_WR;
        else if (rd_cnt_q == num_q) state_d = S_DRAIN;
      end
      S_DRAIN: if (ack_cnt_q == num_q) state_d = S_DSM_WR;
      S_DSM_WR: if (!c1_alm_full) begin
        state_d          = S_DSM_WAIT;
        wr_v_d           = 1'b1;
        wr_addr_d        = dsm_q;
        wr_data_d        = '0;
        wr_data_d[0]     = 1'b1;
        wr_data_d[63:32] = 32'(num_q);
        wr_data_d[95:64] = {31'b0, ovf_q};
      end
      S_DSM_WAIT: if (wr_rsp_valid) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (rd_go) begin
      rd_v_d    = 1'b1;
      rd_addr_d = src_q + ADDR_W'(rd_cnt_q);
      rd_md_d   = rd_cnt_q[15:0];
      rd_cnt_d  = rd_cnt_q + 1'b1;
    end
    if (wr_go) begin
      wr_v_d    = 1'b1;
      wr_addr_d = dst_q + ADDR_W'(wr_cnt_q);
      wr_data_d = mem[rptr_q[AW-1:0]];
      wr_cnt_d  = wr_cnt_q + 1'b1;
      rptr_d    = rptr_q + 1'b1;
    end
    unique case ({rd_go, wr_go})
      2'b10:   credits_d = credits_q + 1'b1;
      2'b01:   credits_d = credits_q - 1'b1;
      default: ;
    endcase
    if (push_ok)                          wptr_d    = wptr_q + 1'b1;
    if (active && dp_valid && !push_ok)   ovf_d     = 1'b1;
    if (active && wr_rsp_valid)           ack_cnt_d = ack_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      dsm_q     <= '0;
      num_q     <= '0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      ack_cnt_q <= '0;
      credits_q <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      rd_v_q    <= 1'b0;
      rd_addr_q <= '0;
      rd_md_q   <= '0;
      wr_v_q    <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      dsm_q     <= dsm_d;
      num_q     <= num_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      ack_cnt_q <= ack_cnt_d;
      credits_q <= credits_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      rd_v_q    <= rd_v_d;
      rd_addr_q <= rd_addr_d;
      rd_md_q   <= rd_md_d;
      wr_v_q    <= wr_v_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Storage only; emptiness is tracked by the reset pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr_q[AW-1:0]] <= dp_data;
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign overflow     = ovf_q;
  assign rd_req_valid = rd_v_q;
  assign rd_req_addr  = rd_addr_q;
  assign rd_req_mdata = rd_md_q;
  assign wr_req_valid = wr_v_q;
  assign wr_req_addr  = wr_addr_q;
  assign wr_req_data  = wr_data_q;
endmodule

// File: doc/gaussian_job_sched.md
Name: gaussian_job_sched

Overview:
- Sequences one Gaussian job end to end: reads `num_lines` cache lines from `src_base`, and writes the datapath results to `dst_base`.
- On completion it posts a status line to `dsm_base`.
- Sits between the CSR block and the requestor's CCI-P channel muxing.
- Owns the read/write address generation, CCI-P almost-full throttling, and a credit-managed result FIFO that absorbs the non-stallable Gaussian pipeline output.

Parameters:
- ADDR_W, 42, cache-line address width (CCI-P line address)
- LEN_W, 32, width of the line count
- FIFO_DEPTH, 64, result FIFO entries (power of 2); also the read-credit limit
- DATA_W, 512, line width

Ports:
- clk  in  1  CCI-P clock (pClk domain)
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle job launch pulse from CSR
- src_base  in  ADDR_W  source line address, sampled on start
- dst_base  in  ADDR_W  destination line address, sampled on start
- dsm_base  in  ADDR_W  status line address, sampled on start
- num_lines  in  LEN_W  lines in job, sampled on start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when status write is acked
- overflow  out  1  sticky: datapath output arrived with FIFO full
- c0_alm_full  in  1  CCI-P c0TxAlmFull
- c1_alm_full  in  1  CCI-P c1TxAlmFull
- rd_req_valid  out  1  registered read request strobe
- rd_req_addr  out  ADDR_W  read line address
- rd_req_mdata  out  16  low 16 bits of the line index
- dp_valid  in  1  Gaussian datapath output valid; no backpressure
- dp_data  in  DATA_W  Gaussian datapath output line
- wr_req_valid  out  1  registered write request strobe
- wr_req_addr  out  ADDR_W  write line address
- wr_req_data  out  DATA_W  write data
- wr_rsp_valid  in  1  CCI-P c1 write response (one per line)

Behaviour:
- Reset (reset_n low, asynchronous):
  - state IDLE; all counters 0; FIFO empty.
  - busy, done, overflow, rd_req_valid, wr_req_valid = 0.
  - Address and data outputs = 0.
  - Reset mid-job aborts immediately; late responses after reset are ignored.
- Datapath contract: exactly one dp_valid per issued read, in issue order.
- States:
  - IDLE: start=1 latches inputs, clears counters and overflow → RUN. start while not IDLE is ignored.
  - RUN: issues reads and writes. When rd_issued == num_lines → DRAIN. num_lines == 0 → DSM_WR directly.
  - DRAIN: issues writes only. When wr_acked == num_lines → DSM_WR.
  - DSM_WR: on the first edge with c1_alm_full == 0, issue the status write → DSM_WAIT.
  - DSM_WAIT: on wr_rsp_valid → IDLE, with done=1 for that one cycle.
- Read issue (RUN only), on an edge where all of these hold:
  - c0_alm_full == 0
  - rd_issued < num_lines
  - credits < FIFO_DEPTH
- A read issue sets, for one cycle:
  - rd_req_valid = 1
  - rd_req_addr = src_base + rd_issued
  - rd_req_mdata = rd_issued[15:0]
- A read issue increments rd_issued and credits.
- Latency: start sampled at edge N → first rd_req_valid visible after edge N+1. Throughput 1 request/cycle.
- Result FIFO: dp_valid pushes dp_data. A push while full drops the line and sets overflow sticky (cleared only by start or reset).
- Write issue (RUN or DRAIN), on an edge where FIFO is non-empty and c1_alm_full == 0:
  - wr_req_valid = 1
  - wr_req_addr = dst_base + wr_issued
  - wr_req_data = FIFO head (popped)
  - Increments wr_issued; decrements credits.
- A simultaneous read issue and write issue leaves credits unchanged.
- wr_rsp_valid increments wr_acked in RUN/DRAIN.
- Simultaneous push and pop with FIFO full is legal.
- Status write: wr_req_addr = dsm_base; wr_req_data[0] = 1, [63:32] = num_lines, [95:64] = overflow, all other bits 0.
- busy = (state != IDLE). Counters are LEN_W wide; address add wraps modulo 2^ADDR_W.
- c0 and c1 are independent: a read and a write may issue on the same edge.

Test Plan:
- num_lines=4, src_base=0x1000, dst_base=0x2000, dsm_base=0x3000, datapath delay 10, no alm_full:
  - reads to 0x1000..0x1003 with mdata 0..3 on consecutive cycles
  - writes to 0x2000..0x2003 in order
  - after 4 wr_rsp, status write to 0x3000 with data[0]=1, [63:32]=4
  - done pulses once; busy falls the same cycle.
- num_lines=200, FIFO_DEPTH=64, c1_alm_full held 1 for 500 cycles → reads stop after 64 issued; overflow stays 0. After release, all 200 lines written; done asserted.
- c0_alm_full toggled every other cycle → no rd_req_valid on any edge with c0_alm_full=1; addresses stay contiguous with no gaps or repeats.
- num_lines=0 → no reads or data writes; status write with data[63:32]=0 issued; done after its wr_rsp.
- Inject an extra dp_valid while FIFO full → overflow=1 and status data[64]=1. Then start again → overflow cleared.
- reset_n low mid-RUN, e.g. after 10 reads → all outputs 0 asynchronously; IDLE; a subsequent start runs a fresh job correctly.
